// File: rtl/mini16_pkg.sv
// Shared types and item-layout helpers for the mini16 collector/broadcaster family.
// No logic of its own; latency not applicable.
// No flow control; consumers own their handshakes.
package mini16_pkg;

  // Collector sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Width of a core index; a single core still gets one bit so ports never collapse.
  function automatic int unsigned idx_width(input int unsigned n_cores);
    return (n_cores < 2) ? 1 : $clog2(n_cores);
  endfunction

  // Item = {addr, data}: the address sits directly above the data field.
  function automatic int unsigned item_width(input int unsigned width_d, input int unsigned depth_v_f);
    return width_d + depth_v_f;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned width_d);
    return width_d;
  endfunction

  function automatic int unsigned data_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/mini16_s2m_collector_rr_pointer.sv
// Round-robin core pointer with a per-core burst counter.
// Updates on the clock edge after skip/bump; pointer is registered.
// No handshake: the owner pulses skip (core empty) or bump (one item consumed).
module mini16_s2m_collector_rr_pointer
  import mini16_pkg::*;
#(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = idx_width(N_CORES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             skip,
  input  logic             bump,
  output logic [IDX_W-1:0] ptr
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_next;
  logic [BURST_W-1:0] burst_q, burst_d;

  assign ptr = ptr_q;

  // Wrap at the last core; with a single core this is permanently zero.
  assign ptr_next = (ptr_q == IDX_W'(N_CORES - 1)) ? '0 : ptr_q + 1'b1;

  // An empty core moves on at once; a full burst moves on after its last item.
  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (skip) begin
      ptr_d   = ptr_next;
      burst_d = '0;
    end else if (bump) begin
      if (burst_q == BURST_W'(MAX_BURST - 1)) begin
        ptr_d   = ptr_next;
        burst_d = '0;
      end else begin
        burst_d = burst_q + 1'b1;
      end
    end
  end

  // Pointer and burst registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/mini16_s2m_collector.sv
// Drains N_CORES slave-to-master FIFOs round-robin and writes each item into the master space.
// Item valid at the sample cycle appears on m_we one cycle later; one write per FIFO_LATENCY+2 cycles.
// m_full/enable gate only the next request; an item already popped is always written.
module mini16_s2m_collector
  import mini16_pkg::*;
#(
  parameter int unsigned N_CORES      = 4,
  parameter int unsigned WIDTH_D      = 16,
  parameter int unsigned DEPTH_V_F    = 16,
  parameter int unsigned FIFO_LATENCY = 2,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  input  logic                                       m_full,
  output logic [N_CORES-1:0]                         fifo_req_r,
  input  logic [N_CORES-1:0]                         fifo_valid,
  input  logic [N_CORES*(WIDTH_D+DEPTH_V_F)-1:0]     fifo_r_data,
  output logic                                       m_we,
  output logic [DEPTH_V_F-1:0]                       m_addr,
  output logic [WIDTH_D-1:0]                         m_data,
  output logic [idx_width(N_CORES)-1:0]              m_core,
  output logic                                       busy,
  output logic [15:0]                                item_count
);

  localparam int unsigned ITEM_W = item_width(WIDTH_D, DEPTH_V_F);
  localparam int unsigned IDX_W  = idx_width(N_CORES);
  localparam int unsigned LAT_W  = $clog2(FIFO_LATENCY + 1);
  localparam int unsigned A_LSB  = addr_lsb(WIDTH_D);
  localparam int unsigned D_LSB  = data_lsb();

  state_e               state_q, state_d;
  logic [LAT_W-1:0]     wait_q, wait_d;
  logic [DEPTH_V_F-1:0] addr_q, addr_d;
  logic [WIDTH_D-1:0]   data_q, data_d;
  logic [IDX_W-1:0]     core_q, core_d;
  logic [15:0]          count_q, count_d;

  logic [IDX_W-1:0]     ptr;
  logic                 ptr_skip, ptr_bump;
  logic                 sel_vld;
  logic [ITEM_W-1:0]    sel_item;
  logic                 go;

  mini16_s2m_collector_rr_pointer #(
    .N_CORES   (N_CORES),
    .MAX_BURST (MAX_BURST),
    .IDX_W     (IDX_W)
  ) u_rr_pointer (
    .clk   (clk),
    .reset (reset),
    .skip  (ptr_skip),
    .bump  (ptr_bump),
    .ptr   (ptr)
  );

  assign go         = enable && !m_full;
  assign m_we       = (state_q == ST_WRITE);
  assign busy       = (state_q != ST_IDLE);
  assign m_addr     = addr_q;
  assign m_data     = data_q;
  assign m_core     = core_q;
  assign item_count = count_q;

  // Select the pointed-to core's valid/item and raise its request only in REQ.
  always_comb begin
    sel_vld    = 1'b0;
    sel_item   = '0;
    fifo_req_r = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (ptr == IDX_W'(i)) begin
        sel_vld       = fifo_valid[i];
        sel_item      = fifo_r_data[i*ITEM_W +: ITEM_W];
        fifo_req_r[i] = (state_q == ST_REQ);
      end
    end
  end

  // Sequencer: request, wait out the FIFO read latency, then write or move on.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    data_d   = data_q;
    core_d   = core_q;
    count_d  = count_q;
    ptr_skip = 1'b0;
    ptr_bump = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_REQ;
      end
      ST_REQ: begin
        wait_d  = LAT_W'(FIFO_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else if (sel_vld) begin
          addr_d  = sel_item[A_LSB +: DEPTH_V_F];
          data_d  = sel_item[D_LSB +: WIDTH_D];
          core_d  = ptr;
          state_d = ST_WRITE;
        end else begin
          ptr_skip = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        count_d  = count_q + 16'd1;
        ptr_bump = 1'b1;
        state_d  = go ? ST_REQ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latency counter and registered write outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      core_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      core_q  <= core_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mini16_s2m_collector.sv
// Bench for mini16_s2m_collector: PE FIFO models, write scoreboard, directed and random phases.
// Reference order comes from draining per-PE queues by the round-robin/burst rules.
// Backpressure and enable are exercised by toggling m_full/enable around the DUT.
module tb_mini16_s2m_collector;

  localparam int N   = 4;
  localparam int WD  = 16;
  localparam int WA  = 16;
  localparam int LAT = 2;
  localparam int MB  = 4;
  localparam int IW  = WD + WA;

  logic            clk = 1'b0;
  logic            reset, enable, m_full;
  logic [N-1:0]    fifo_req_r, fifo_valid;
  logic [N*IW-1:0] fifo_r_data;
  logic            m_we, busy;
  logic [WA-1:0]   m_addr;
  logic [WD-1:0]   m_data;
  logic [1:0]      m_core;
  logic [15:0]     item_count;

  always #5 clk = ~clk;

  mini16_s2m_collector #(
    .N_CORES(N), .WIDTH_D(WD), .DEPTH_V_F(WA), .FIFO_LATENCY(LAT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .m_full(m_full),
    .fifo_req_r(fifo_req_r), .fifo_valid(fifo_valid), .fifo_r_data(fifo_r_data),
    .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .m_core(m_core),
    .busy(busy), .item_count(item_count)
  );

  typedef struct packed {
    logic [1:0]    core;
    logic [WA-1:0] addr;
    logic [WD-1:0] data;
  } wr_t;

  int errors = 0;
  int checks = 0;

  wr_t          exp_q[$];
  logic [IW-1:0] pe_q[N][$];
  int           cnt[N];
  int           noise_mode = 0;
  int           cyc = 0;
  logic         rst_e = 1'b1, en_e = 1'b0, full_e = 1'b0;
  int           req_cyc[$];
  logic [N-1:0] req_vec[$];
  int           wr_core_log[$];
  int           last_req_cyc = -100;
  int           last_req_core = 0;
  int           n_wr = 0;
  bit           cnt_pend = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Inputs as the DUT saw them at the last rising edge.
  always @(posedge clk) begin
    cyc    = cyc + 1;
    rst_e  = reset;
    en_e   = enable;
    full_e = m_full;
  end

  // PE FIFO models: a request seen in cycle t pops the queue head onto valid/data in cycle t+LAT.
  // Every other core/cycle carries junk valid and data.
  always @(negedge clk) begin : pe_fifos
    logic [N-1:0]    v;
    logic [N*IW-1:0] d;
    v = (noise_mode == 1) ? N'(4'b0011) : N'($urandom);
    d = {$urandom, $urandom, $urandom, $urandom};
    if (rst_e) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] = -1;
        pe_q[i].delete();
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) begin
            v[i] = (pe_q[i].size() > 0);
            if (v[i]) d[i*IW +: IW] = pe_q[i].pop_front();
            cnt[i] = -1;
          end
        end
        if (fifo_req_r[i]) cnt[i] = LAT;
      end
    end
    fifo_valid  = v;
    fifo_r_data = d;
  end

  // Monitor: request legality, write scoreboard, write latency, item counter.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_e) begin
      n_wr         = 0;
      cnt_pend     = 0;
      last_req_cyc = -100;
    end else begin
      if (cnt_pend) begin
        chk("item_count_after_write", item_count, n_wr & 16'hFFFF);
        cnt_pend = 0;
      end
      if (fifo_req_r != '0) begin
        chk("req_onehot", $onehot(fifo_req_r), 1);
        chk("req_allowed", (en_e && !full_e), 1);
        chk("busy_in_req", busy, 1);
        req_cyc.push_back(cyc);
        req_vec.push_back(fifo_req_r);
        last_req_cyc  = cyc;
        last_req_core = $clog2(fifo_req_r);
      end
      if (m_we) begin
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_write core=%0d addr=%h data=%h, none due", m_core, m_addr, m_data));
        end else begin
          e = exp_q.pop_front();
          chk("wr_core", m_core, e.core);
          chk("wr_addr", m_addr, e.addr);
          chk("wr_data", m_data, e.data);
        end
        chk("wr_latency_from_req", cyc - last_req_cyc, LAT + 1);
        chk("wr_core_matches_req", m_core, last_req_core);
        wr_core_log.push_back(int'(m_core));
        n_wr++;
        cnt_pend = 1;
      end
    end
  end

  task automatic clear_logs();
    req_cyc.delete();
    req_vec.delete();
    wr_core_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; m_full = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    clear_logs();
  endtask

  task automatic add_item(input int core, input logic [WA-1:0] a, input logic [WD-1:0] dt);
    pe_q[core].push_back({a, dt});
  endtask

  // Reference drain order: visit cores in turn, take up to MB items, move on when empty.
  task automatic build_expected();
    logic [IW-1:0] cp[N][$];
    logic [IW-1:0] it;
    int p = 0, b = 0, empties = 0;
    for (int i = 0; i < N; i++) cp[i] = pe_q[i];
    exp_q.delete();
    while (empties < N) begin
      if (cp[p].size() > 0) begin
        it = cp[p].pop_front();
        exp_q.push_back('{core: 2'(p), addr: it[IW-1:WD], data: it[WD-1:0]});
        empties = 0;
        b++;
        if (b == MB) begin b = 0; p = (p + 1) % N; end
      end else begin
        empties++;
        b = 0;
        p = (p + 1) % N;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req();
    int k = 0;
    bit ok = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (fifo_req_r != '0) ok = 1;
      k++;
    end
    if (!ok) fail_now("req_timeout");
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int total, c0, k, nit;
    int fair_order[12];
    logic [N-1:0] ev;
    fair_order = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 3, 3};
    reset = 1'b1; enable = 1'b0; m_full = 1'b0;
    fifo_valid = '0; fifo_r_data = '0;
    for (int i = 0; i < N; i++) cnt[i] = -1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_fifo_req_r", fifo_req_r, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_core", m_core, 0);
    chk("rst_busy", busy, 0);
    chk("rst_item_count", item_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single item on PE2.
    clear_logs();
    add_item(2, 16'h0123, 16'hBEEF);
    build_expected();
    enable = 1'b1;
    wait_drain(200);
    chk("single_item_count", item_count, 1);
    if (req_vec.size() >= 3) chk("single_third_req", req_vec[2], 4'b0100);
    else fail_now("single_too_few_reqs");

    // Round-robin fairness with bursts.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      add_item(0, 16'(16'h0A00 + i), 16'($urandom));
      add_item(3, 16'(16'h3A00 + i), 16'($urandom));
    end
    build_expected();
    enable = 1'b1;
    wait_drain(500);
    chk("fair_item_count", item_count, 12);
    chk("fair_write_count", wr_core_log.size(), 12);
    for (int i = 0; i < 12 && i < wr_core_log.size(); i++)
      chk($sformatf("fair_order[%0d]", i), wr_core_log[i], fair_order[i]);

    // Empty fabric: requests rotate, spaced LAT+2, no writes.
    do_reset();
    enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("empty_enough_reqs", (req_vec.size() >= 9), 1);
    for (int i = 0; i < req_vec.size(); i++) begin
      ev = N'(1) << (i % N);
      chk($sformatf("empty_req[%0d]", i), req_vec[i], ev);
      if (i > 0) chk($sformatf("empty_gap[%0d]", i), req_cyc[i] - req_cyc[i-1], LAT + 2);
    end
    chk("empty_no_writes", wr_core_log.size(), 0);

    // Backpressure raised while an item is in flight.
    do_reset();
    for (int i = 0; i < 3; i++) add_item(0, 16'(16'h5500 + i), 16'($urandom));
    build_expected();
    enable = 1'b1;
    wait_req();
    @(negedge clk);
    m_full = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    chk("full_inflight_written", wr_core_log.size(), 1);
    chk("full_no_reqs", req_vec.size(), 0);
    m_full = 1'b0;
    c0 = cyc;
    wait_req();
    chk("full_resume_cycle", cyc - c0, 1);
    chk("full_resume_ptr", fifo_req_r, 4'b0001);
    wait_drain(200);
    chk("full_item_count", item_count, 3);

    // Spurious valids on unselected cores and outside the sample cycle.
    do_reset();
    noise_mode = 1;
    enable = 1'b1;
    repeat (12) @(negedge clk);
    if (req_vec.size() >= 2) begin
      chk("spur_first_req", req_vec[0], 4'b0001);
      chk("spur_second_req", req_vec[1], 4'b0010);
    end else fail_now("spur_too_few_reqs");
    chk("spur_no_writes", wr_core_log.size(), 0);
    noise_mode = 0;

    // Reset during a write.
    do_reset();
    for (int i = 0; i < 6; i++) add_item(0, 16'(16'h7700 + i), 16'($urandom));
    build_expected();
    enable = 1'b1;
    k = 0;
    while (m_we !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (m_we !== 1'b1) fail_now("midreset_no_write");
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_m_we", m_we, 0);
    chk("midreset_item_count", item_count, 0);
    chk("midreset_req", fifo_req_r, 0);
    chk("midreset_busy", busy, 0);
    exp_q.delete();
    reset = 1'b0;
    wait_req();
    chk("midreset_first_req", fifo_req_r, 4'b0001);
    repeat (10) @(negedge clk);

    // Randomised fill with random enable/backpressure.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      total = 0;
      for (int p = 0; p < N; p++) begin
        nit = $urandom_range(0, 7);
        for (int i = 0; i < nit; i++) add_item(p, 16'($urandom), 16'($urandom));
        total += nit;
      end
      build_expected();
      k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
        enable = ($urandom_range(0, 7) != 0);
        m_full = ($urandom_range(0, 5) == 0);
        @(negedge clk);
        k++;
      end
      enable = 1'b1;
      m_full = 1'b0;
      chk($sformatf("rand%0d_drained", r), exp_q.size(), 0);
      repeat (4) @(negedge clk);
      chk($sformatf("rand%0d_item_count", r), item_count, total);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
